// File: rtl/mulacc_sched_pkg.sv
// Shared types and helpers for the mulacc round-robin scheduler.
//   sched_state_t : scheduler FSM states
//   DEF_NREQ      : default number of requesters
//   DEF_WIDTH     : default operand/accumulator width
//   rr_next()     : round-robin pointer advance, (ptr + 1) mod nreq
package mulacc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COMMIT,
        RESP
    } sched_state_t;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 8;

    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned nreq = DEF_NREQ);
        return (ptr + 1 >= nreq) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mulacc_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester
//   ptr     : highest-priority requester index for this decision
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : index of the granted requester
//   any     : at least one request present
module rr_arbiter
    import mulacc_sched_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    int unsigned    idx;
    logic [IDW-1:0] sel;

    // Scan NREQ positions starting at ptr, wrapping; the first requester hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = IDW'(idx);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/mulacc_sched.sv
// Round-robin scheduler sharing one mulacc unit among NREQ requesters.
//   clk, reset              : clock, synchronous active-high reset (shared with mulacc)
//   req_valid/req_x/req_ready : per-requester operand handshake (req_ready one-hot, IDLE only)
//   rsp_valid/rsp_ready     : per-requester response handshake (rsp_valid one-hot)
//   rsp_data, rsp_ovf       : accumulator and sticky overflow returned in RESP
//   mac_en, mac_x           : two-cycle enable sequence (multiply, commit) to mulacc
//   mac_out, mac_overflow   : mulacc results
//   busy                    : high in any state other than IDLE
//   ovf_owner(_vld)         : requester whose operation first raised overflow
module mulacc_sched
    import mulacc_sched_pkg::*;
#(
    parameter  int unsigned NREQ  = DEF_NREQ,
    parameter  int unsigned WIDTH = DEF_WIDTH,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_x,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_ovf,
    output logic                  mac_en,
    output logic [WIDTH-1:0]      mac_x,
    input  logic [WIDTH-1:0]      mac_out,
    input  logic                  mac_overflow,
    output logic                  busy,
    output logic [IDW-1:0]        ovf_owner,
    output logic                  ovf_owner_vld
);

    sched_state_t     state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_q;
    logic [WIDTH-1:0] x_q;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;
    logic [WIDTH-1:0] req_x_arr [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_x_arr[i] = req_x[i*WIDTH +: WIDTH];
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Accept strobe is combinational in IDLE; suppressed while reset is held so
    // a requester never sees an accept that the FSM does not act on.
    always_comb begin
        req_ready = '0;
        rsp_data  = '0;
        rsp_ovf   = 1'b0;
        if (state == IDLE && !reset) begin
            req_ready = arb_gnt;
        end
        if (state == RESP) begin
            rsp_data = mac_out;
            rsp_ovf  = mac_overflow;
        end
    end

    // mac_en is high exactly in ISSUE and COMMIT, so it also gates the operand.
    assign mac_x = mac_en ? x_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            gnt_q         <= '0;
            x_q           <= '0;
            mac_en        <= 1'b0;
            busy          <= 1'b0;
            rsp_valid     <= '0;
            ovf_owner     <= '0;
            ovf_owner_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        x_q    <= req_x_arr[arb_idx];
                        gnt_q  <= arb_idx;
                        mac_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= COMMIT;
                end
                COMMIT: begin
                    mac_en    <= 1'b0;
                    rsp_valid <= NREQ'(1) << gnt_q;
                    state     <= RESP;
                end
                RESP: begin
                    if (mac_overflow && !ovf_owner_vld) begin
                        ovf_owner     <= gnt_q;
                        ovf_owner_vld <= 1'b1;
                    end
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        ptr       <= IDW'(rr_next(32'(gnt_q), NREQ));
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mulacc_sched.md
# mulacc_sched

Round-robin scheduler sharing one `mulacc` multiply-accumulate unit among `NREQ` requesters. Each requester offers an operand over a valid/ready handshake. The scheduler grants one requester at a time and drives the unit's two-phase enable sequence (multiply, then commit). It then returns the updated accumulator and overflow flag to the granted requester over a response handshake. It sits between requester logic and a single `mulacc` instance, which shares its `reset` net.

## Interface
- `NREQ`, 4: number of requesters, 2..16
- `WIDTH`, 8: operand/accumulator width; must equal the `mulacc` `WIDTH`
- `IDW`, $clog2(NREQ): requester index width (derived, not overridable)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high; same net drives the `mulacc` instance
- `req_valid`  in  NREQ  requester i has an operand
- `req_x`  in  NREQ*WIDTH  operand of requester i at bits [i*WIDTH +: WIDTH]
- `req_ready`  out  NREQ  one-hot accept strobe
- `rsp_valid`  out  NREQ  one-hot response valid
- `rsp_ready`  in  NREQ  requester i consumes its response
- `rsp_data`  out  WIDTH  accumulator after the granted operation
- `rsp_ovf`  out  1  sticky overflow of the shared unit
- `mac_en`  out  1  to `mulacc.en`
- `mac_x`  out  WIDTH  to `mulacc.x`
- `mac_out`  in  WIDTH  from `mulacc.out`
- `mac_overflow`  in  1  from `mulacc.overflow`
- `busy`  out  1  high in any state other than IDLE
- `ovf_owner`  out  IDW  index of the requester whose operation first raised overflow
- `ovf_owner_vld`  out  1  `ovf_owner` is valid

## Operation
- **FSM states:** IDLE, ISSUE, COMMIT, RESP.
- **IDLE:**
  - If any `req_valid` is set, pick the winner by round-robin starting at pointer `ptr`.
  - Assert `req_ready[g]` combinationally the same cycle.
  - Capture `req_x[g]` into `x_q` and `g` into `gnt_q`.
  - Go to ISSUE.
- **ISSUE:** `mac_en`=1, `mac_x`=`x_q` (unit multiplies) -> COMMIT.
- **COMMIT:** `mac_en`=1, `mac_x`=`x_q` (unit writes `acc`/`out`, updates overflow) -> RESP.
- **RESP:**
  - `rsp_valid[gnt_q]`=1; `rsp_data`=`mac_out`; `rsp_ovf`=`mac_overflow` (pass-through, stable because `mac_en`=0).
  - On `rsp_ready[gnt_q]` -> IDLE and set `ptr` = (`gnt_q`+1) mod NREQ.
- **Outside ISSUE/COMMIT:** `mac_en`=0 and `mac_x`=0.
- **ovf_owner:**
  - In RESP, if `mac_overflow`=1 and `ovf_owner_vld`=0, load `ovf_owner`=`gnt_q` and set `ovf_owner_vld`.
  - Both hold until `reset`.
- **Arbitration:**
  - Only requesters whose `req_valid` is set are considered.
  - `rsp_ready` of non-granted requesters is ignored.
  - A requester must hold `req_valid`/`req_x` stable until `req_ready`.
  - Dropping `req_valid` before grant is legal; that request is simply not served.
- **Reset:**
  - State IDLE, `ptr`=0, `x_q`=0, `gnt_q`=0.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_data` (IDLE drives 0), `rsp_ovf`, `mac_en`, `mac_x`, `busy`, `ovf_owner`, `ovf_owner_vld`.
- **Reset mid-operation (ISSUE/COMMIT/RESP):**
  - Abort with no response.
  - The unit is reset on the same edge, so its phase stays aligned with the FSM.

## Timing
- Accept at cycle t (IDLE, `req_ready[g]`=1).
- Cycles t+1 and t+2: `mac_en`=1.
- Cycle t+3: `rsp_valid[g]`=1.
- If `rsp_ready` is already high at t+3, IDLE at t+4; the next accept is no earlier than t+4. Peak throughput is 1 op / 4 cycles.
- `rsp_valid` holds indefinitely under backpressure; `mac_en` stays 0 while waiting.
- `req_ready` is never asserted outside IDLE, and never for more than one requester.
- `busy` is 0 only in IDLE.

## Structure
- **Package `mulacc_sched_pkg`:**
  - state enum `sched_state_t` {IDLE, ISSUE, COMMIT, RESP}
  - default `NREQ`/`WIDTH` constants
  - function `rr_next(ptr)` = (ptr+1) mod NREQ
- **Sub-module `rr_arbiter`:**
  - Inputs: `req` vector, `ptr`.
  - Outputs: one-hot `gnt`, `gnt_idx`, `any`.
  - Purely combinational.
  - The pointer register stays in `mulacc_sched`.

## Test plan
- **Single requester:** reset, then req 0 with x=3 -> `req_ready[0]` at t, `mac_en` at t+1..t+2 with `mac_x`=3, `rsp_valid[0]` at t+3, `rsp_data` = `mac_out`; with acc preloaded to 2, `rsp_data`=6.
- **Round-robin fairness:** all four `req_valid` held high -> grant order 0,1,2,3,0; exactly 4 cycles between accepts with `rsp_ready` tied high.
- **Backpressure:** `rsp_ready[1]` low for 5 cycles -> `rsp_valid[1]` held, `rsp_data` stable, `mac_en`=0, no `req_ready` asserted; IDLE the cycle after `rsp_ready` rises.
- **Overflow owner:** WIDTH=8, acc=16, requester 2 sends x=16 -> `rsp_ovf`=1, `ovf_owner`=2, `ovf_owner_vld`=1; a later overflow by requester 3 leaves `ovf_owner`=2.
- **Reset in COMMIT:** assert `reset` one cycle during COMMIT -> no `rsp_valid`, `busy`=0, `ptr`=0, and the next request is served with normal t..t+3 timing.
- **Sparse / non-granted ready:** `req_valid` only on 1 and 3, `ptr`=2 -> 3 granted first; `rsp_ready[0]` pulses during RESP are ignored.
